// File: rtl/execute_stage_pipe.sv
// execute_stage_pipe: RV32I/RV64I execute stage with forwarding, branch/jump redirect and EX/MEM register.
// Define EX_MUL_EN to add the iterative shift-add multiplier FSM.
module execute_stage_pipe #(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_e,
    input  logic            flush_e,
    input  logic            stall_m,
    input  logic            reg_write_e,
    input  logic            mem_write_e,
    input  logic            alu_src_e,
    input  logic            branch_e,
    input  logic            jump_e,
    input  logic            jalr_e,
    input  logic            mul_e,
    input  logic [1:0]      result_src_e,
    input  logic [3:0]      alu_ctrl_e,
    input  logic [2:0]      br_funct3_e,
    input  logic [1:0]      fwd_a_e,
    input  logic [1:0]      fwd_b_e,
    input  logic [4:0]      rd_e,
    input  logic [XLEN-1:0] rd1_e,
    input  logic [XLEN-1:0] rd2_e,
    input  logic [XLEN-1:0] pc_e,
    input  logic [XLEN-1:0] pc_plus4_e,
    input  logic [XLEN-1:0] imm_ext_e,
    input  logic [XLEN-1:0] result_w,
    output logic            ex_busy,
    output logic            pc_src_e,
    output logic [XLEN-1:0] pc_target_e,
    output logic            valid_m,
    output logic            reg_write_m,
    output logic            mem_write_m,
    output logic [1:0]      result_src_m,
    output logic [4:0]      rd_m,
    output logic [XLEN-1:0] alu_result_m,
    output logic [XLEN-1:0] write_data_m,
    output logic [XLEN-1:0] pc_plus4_m
);
    localparam int SH = $clog2(XLEN);
    logic [XLEN-1:0] src_a, fwd_b, src_b, alu_y, res_e, jalr_sum;
    logic            eq, lt_s, lt_u, taken, busy;

    assign src_a = fwd_a_e == 2'b01 ? result_w : fwd_a_e == 2'b10 ? alu_result_m : rd1_e;
    assign fwd_b = fwd_b_e == 2'b01 ? result_w : fwd_b_e == 2'b10 ? alu_result_m : rd2_e;
    assign src_b = alu_src_e ? imm_ext_e : fwd_b;
    assign eq    = src_a == fwd_b;
    assign lt_s  = $signed(src_a) < $signed(fwd_b);
    assign lt_u  = src_a < fwd_b;
    assign taken = br_funct3_e == 3'b000 ? eq   : br_funct3_e == 3'b001 ? ~eq :
                   br_funct3_e == 3'b100 ? lt_s : br_funct3_e == 3'b101 ? ~lt_s :
                   br_funct3_e == 3'b110 ? lt_u : br_funct3_e == 3'b111 ? ~lt_u : 1'b0;

    always_comb begin
        alu_y = '0;
        case (alu_ctrl_e)
            4'd0: alu_y = src_a + src_b;
            4'd1: alu_y = src_a - src_b;
            4'd2: alu_y = src_a & src_b;
            4'd3: alu_y = src_a | src_b;
            4'd4: alu_y = src_a ^ src_b;
            4'd5: alu_y = src_a << src_b[SH-1:0];
            4'd6: alu_y = src_a >> src_b[SH-1:0];
            4'd7: alu_y = $signed(src_a) >>> src_b[SH-1:0];
            4'd8: alu_y = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            4'd9: alu_y = {{(XLEN-1){1'b0}}, src_a < src_b};
            default: alu_y = '0;
        endcase
    end

    assign jalr_sum    = src_a + imm_ext_e;
    assign pc_target_e = jalr_e ? {jalr_sum[XLEN-1:1], 1'b0} : pc_e + imm_ext_e;
    assign pc_src_e    = valid_e & ~flush_e & ~busy & ~stall_m & (jump_e | (branch_e & taken));
    assign ex_busy     = busy;

`ifdef EX_MUL_EN
    localparam int STEPS = XLEN / MUL_STEP;
    localparam int CW    = $clog2(STEPS) + 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t          state, state_n;
    logic [XLEN-1:0] mcand, mplier, acc;
    logic [CW-1:0]   cnt;
    logic            start;

    assign start = valid_e & mul_e & ~flush_e;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? RUN : IDLE;
            RUN:     state_n = flush_e ? IDLE : cnt == CW'(STEPS - 1) ? DONE : RUN;
            DONE:    state_n = (flush_e | ~stall_m) ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end

    // Busy covers the launch cycle plus every RUN cycle; DONE lets the product through.
    always_comb begin
        busy = (state == RUN) | ((state == IDLE) & start);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == IDLE && start) begin
            mcand  <= src_a;
            mplier <= src_b;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == RUN) begin
            acc    <= acc + mcand * XLEN'(mplier[MUL_STEP-1:0]);
            mcand  <= mcand << MUL_STEP;
            mplier <= mplier >> MUL_STEP;
            cnt    <= cnt + CW'(1);
        end
    end

    assign res_e = mul_e ? acc : alu_y;
`else
    logic unused_mul;
    assign unused_mul = mul_e;
    assign busy       = 1'b0;
    assign res_e      = alu_y;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_m      <= 1'b0;
            reg_write_m  <= 1'b0;
            mem_write_m  <= 1'b0;
            result_src_m <= '0;
            rd_m         <= '0;
            alu_result_m <= '0;
            write_data_m <= '0;
            pc_plus4_m   <= '0;
        end else if (!stall_m) begin
            if (flush_e || busy || !valid_e) begin
                valid_m     <= 1'b0;
                reg_write_m <= 1'b0;
                mem_write_m <= 1'b0;
            end else begin
                valid_m      <= 1'b1;
                reg_write_m  <= reg_write_e;
                mem_write_m  <= mem_write_e;
                result_src_m <= result_src_e;
                rd_m         <= rd_e;
                alu_result_m <= res_e;
                write_data_m <= fwd_b;
                pc_plus4_m   <= pc_plus4_e;
            end
        end
    end
endmodule

// File: tb/tb_execute_stage_pipe.sv
// tb_execute_stage_pipe: vector table, hand sequences and randomized run against a behavioural model.
module tb_execute_stage_pipe;
    localparam int XLEN = 32;
    logic            clk = 1'b0, rst = 1'b1;
    logic            valid_e, flush_e, stall_m, reg_write_e, mem_write_e, alu_src_e;
    logic            branch_e, jump_e, jalr_e, mul_e;
    logic [1:0]      result_src_e, fwd_a_e, fwd_b_e;
    logic [3:0]      alu_ctrl_e;
    logic [2:0]      br_funct3_e;
    logic [4:0]      rd_e;
    logic [XLEN-1:0] rd1_e, rd2_e, pc_e, pc_plus4_e, imm_ext_e, result_w;
    logic            ex_busy, pc_src_e, valid_m, reg_write_m, mem_write_m;
    logic [XLEN-1:0] pc_target_e, alu_result_m, write_data_m, pc_plus4_m;
    logic [1:0]      result_src_m;
    logic [4:0]      rd_m;
    int tests = 0, fails = 0;

    execute_stage_pipe #(.XLEN(XLEN), .MUL_STEP(4)) dut (
        .clk(clk), .rst(rst), .valid_e(valid_e), .flush_e(flush_e), .stall_m(stall_m),
        .reg_write_e(reg_write_e), .mem_write_e(mem_write_e), .alu_src_e(alu_src_e),
        .branch_e(branch_e), .jump_e(jump_e), .jalr_e(jalr_e), .mul_e(mul_e),
        .result_src_e(result_src_e), .alu_ctrl_e(alu_ctrl_e), .br_funct3_e(br_funct3_e),
        .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .rd_e(rd_e), .rd1_e(rd1_e), .rd2_e(rd2_e),
        .pc_e(pc_e), .pc_plus4_e(pc_plus4_e), .imm_ext_e(imm_ext_e), .result_w(result_w),
        .ex_busy(ex_busy), .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
        .valid_m(valid_m), .reg_write_m(reg_write_m), .mem_write_m(mem_write_m),
        .result_src_m(result_src_m), .rd_m(rd_m), .alu_result_m(alu_result_m),
        .write_data_m(write_data_m), .pc_plus4_m(pc_plus4_m)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        {valid_e, flush_e, stall_m, reg_write_e, mem_write_e, alu_src_e} = '0;
        {branch_e, jump_e, jalr_e, mul_e} = '0;
        {result_src_e, fwd_a_e, fwd_b_e, alu_ctrl_e, br_funct3_e, rd_e} = '0;
        {rd1_e, rd2_e, pc_e, pc_plus4_e, imm_ext_e, result_w} = '0;
    endtask

    function automatic logic [31:0] m_fwd(input logic [1:0] s, input logic [31:0] rf, input logic [31:0] rw,
                                          input logic [31:0] am);
        return s == 2'd1 ? rw : s == 2'd2 ? am : rf;
    endfunction

    // Operations evaluated as integer arithmetic on 64-bit values, then reduced mod 2^32.
    function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        p  = longint'(1) << (ub % 32);
        case (op)
            4'd0: r = ua + ub;
            4'd1: r = ua - ub;
            4'd2: r = longint'(a & b);
            4'd3: r = longint'(a | b);
            4'd4: r = longint'(a ^ b);
            4'd5: r = ua * p;
            4'd6: r = ua / p;
            4'd7: r = sa >= 0 ? sa / p : -((-sa + p - 1) / p);
            4'd8: r = longint'(sa < sb);
            4'd9: r = longint'(ua < ub);
            default: r = 0;
        endcase
        return 32'(r);
    endfunction

    function automatic logic m_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    typedef struct packed {
        logic [3:0]  op;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        logic        tk;
    } vec_t;

    vec_t vecs[14];
    logic [31:0] em_alu, em_wd, em_pc4, ea, eb, esb, e_tgt;
    logic [4:0]  em_rd;
    logic [1:0]  em_rs;
    logic        em_v, em_rw, em_mw, e_src;
    int          n;

    initial begin
        vecs[0]  = '{4'd0,  3'd0, 32'd5,          32'd7,          32'd12,         1'b0};
        vecs[1]  = '{4'd1,  3'd1, 32'd5,          32'd7,          32'hFFFF_FFFE,  1'b1};
        vecs[2]  = '{4'd2,  3'd4, 32'hF0F0_00FF,  32'h0FF0_0F0F,  32'h00F0_000F,  1'b1};
        vecs[3]  = '{4'd3,  3'd5, 32'h0000_1200,  32'h0000_0034,  32'h0000_1234,  1'b1};
        vecs[4]  = '{4'd4,  3'd6, 32'hFFFF_0000,  32'h0F0F_0F0F,  32'hF0F0_0F0F,  1'b0};
        vecs[5]  = '{4'd5,  3'd7, 32'h1,          32'h24,         32'h10,         1'b0};
        vecs[6]  = '{4'd6,  3'd2, 32'h8000_0000,  32'h1F,         32'h1,          1'b0};
        vecs[7]  = '{4'd7,  3'd3, 32'h8000_0000,  32'h4,          32'hF800_0000,  1'b0};
        vecs[8]  = '{4'd8,  3'd4, 32'hFFFF_FFFF,  32'h1,          32'h1,          1'b1};
        vecs[9]  = '{4'd9,  3'd6, 32'hFFFF_FFFF,  32'h1,          32'h0,          1'b0};
        vecs[10] = '{4'd10, 3'd0, 32'h3,          32'h4,          32'h0,          1'b0};
        vecs[11] = '{4'd15, 3'd0, 32'h9,          32'h9,          32'h0,          1'b1};
        vecs[12] = '{4'd0,  3'd6, 32'h1,          32'hFFFF_FFFF,  32'h0,          1'b1};
        vecs[13] = '{4'd0,  3'd4, 32'h1,          32'hFFFF_FFFF,  32'h0,          1'b0};

        idle();
        rst = 1'b1;
        tick();
        tick();
        chk("reset_valid_m", valid_m, 0);
        chk("reset_alu_m", alu_result_m, 0);
        chk("reset_busy", ex_busy, 0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            valid_e = 1'b1; branch_e = 1'b1; reg_write_e = 1'b1;
            alu_ctrl_e = vecs[i].op; br_funct3_e = vecs[i].f3;
            rd1_e = vecs[i].a; rd2_e = vecs[i].b; rd_e = 5'(i + 1);
            #1;
            chk($sformatf("vec%0d_pc_src", i), pc_src_e, vecs[i].tk);
            tick();
            chk($sformatf("vec%0d_alu", i), alu_result_m, vecs[i].y);
            chk($sformatf("vec%0d_wdata", i), write_data_m, vecs[i].b);
            chk($sformatf("vec%0d_rd", i), rd_m, i + 1);
            chk($sformatf("vec%0d_valid", i), valid_m, 1);
        end
        branch_e = 1'b0;

        rd1_e = 32'd60; rd2_e = 32'd40; alu_ctrl_e = 4'd0;
        tick();
        chk("fwd_seed_alu", alu_result_m, 100);
        rd1_e = 32'd5; rd2_e = 32'd7; fwd_a_e = 2'b10;
        tick();
        chk("fwd_a_m_alu", alu_result_m, 107);
        fwd_a_e = 2'b00; fwd_b_e = 2'b01; result_w = 32'd3;
        tick();
        chk("fwd_b_w_wdata", write_data_m, 3);
        chk("fwd_b_w_alu", alu_result_m, 8);
        alu_src_e = 1'b1; imm_ext_e = 32'h20;
        tick();
        chk("alu_src_imm", alu_result_m, 32'h25);
        chk("alu_src_wdata", write_data_m, 3);

        alu_src_e = 1'b0; fwd_b_e = 2'b00; rd2_e = 32'h0;
        rd1_e = 32'h1001; imm_ext_e = 32'h4; jump_e = 1'b1; jalr_e = 1'b1;
        #1;
        chk("jalr_target", pc_target_e, 32'h1004);
        chk("jalr_pc_src", pc_src_e, 1);
        stall_m = 1'b1;
        #1;
        chk("stall_gates_pc_src", pc_src_e, 0);
        tick();
        chk("stall_hold_alu", alu_result_m, 32'h25);
        chk("stall_hold_wdata", write_data_m, 3);
        flush_e = 1'b1;
        tick();
        chk("stall_flush_hold_valid", valid_m, 1);
        stall_m = 1'b0;
        #1;
        chk("flush_gates_pc_src", pc_src_e, 0);
        tick();
        chk("flush_bubble_valid", valid_m, 0);
        chk("flush_bubble_rw", reg_write_m, 0);
        chk("flush_data_hold", alu_result_m, 32'h25);
        flush_e = 1'b0; jalr_e = 1'b0; pc_e = 32'h2000; imm_ext_e = 32'h10; pc_plus4_e = 32'h2004;
        #1;
        chk("jal_target", pc_target_e, 32'h2010);
        chk("jal_pc_src", pc_src_e, 1);
        tick();
        chk("jal_pc4_m", pc_plus4_m, 32'h2004);
        chk("jal_alu_m", alu_result_m, 32'h1001);
        jump_e = 1'b0; valid_e = 1'b0;
        tick();
        chk("invalid_bubble", valid_m, 0);

`ifdef EX_MUL_EN
        idle();
        valid_e = 1'b1; mul_e = 1'b1; reg_write_e = 1'b1; rd_e = 5'd9;
        rd1_e = 32'h0001_0003; rd2_e = 32'h10;
        #1;
        n = 0;
        while (ex_busy === 1'b1 && n < 40) begin
            chk("mul_bubble", valid_m, 0);
            tick();
            n++;
        end
        chk("mul_busy_cycles", n, 9);
        tick();
        chk("mul_product", alu_result_m, 32'h0010_0030);
        chk("mul_valid", valid_m, 1);
        chk("mul_rd", rd_m, 9);
        rd1_e = 32'h1234_5678; rd2_e = 32'h3;
        #1;
        n = 0;
        while (ex_busy === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("mul2_busy_cycles", n, 9);
        stall_m = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("done_stall_alu", alu_result_m, 32'h0010_0030);
            chk("done_stall_valid", valid_m, 0);
            chk("done_stall_busy", ex_busy, 0);
        end
        stall_m = 1'b0;
        tick();
        chk("done_release_product", alu_result_m, 32'h369D_0368);
        chk("done_release_valid", valid_m, 1);
        rd1_e = 32'd7; rd2_e = 32'd6;
        for (int i = 0; i < 4; i++) tick();
        chk("run_busy", ex_busy, 1);
        flush_e = 1'b1;
        tick();
        chk("flush_run_busy", ex_busy, 0);
        flush_e = 1'b0; valid_e = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("flush_run_valid", valid_m, 0);
            chk("flush_run_busy_after", ex_busy, 0);
            chk("flush_run_no_write", alu_result_m, 32'h369D_0368);
        end
`else
        idle();
        valid_e = 1'b1; mul_e = 1'b1; reg_write_e = 1'b1;
        rd1_e = 32'h0001_0003; rd2_e = 32'h10;
        #1;
        chk("nomul_busy", ex_busy, 0);
        tick();
        chk("nomul_add", alu_result_m, 32'h0001_0013);
        chk("nomul_valid", valid_m, 1);
        for (int i = 0; i < 10; i++) begin
            flush_e = (i == 4);
            tick();
            chk("nomul_never_busy", ex_busy, 0);
            chk("nomul_valid_seq", valid_m, i != 4);
        end
        flush_e = 1'b0;
`endif

        idle();
        valid_e = 1'b1; mul_e = 1'b1; reg_write_e = 1'b1; mem_write_e = 1'b1; result_src_e = 2'd2;
        rd_e = 5'd17; rd1_e = 32'h55; rd2_e = 32'h3; pc_plus4_e = 32'h44; jump_e = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        #2;
        rst = 1'b1; valid_e = 1'b0;
        #1;
        chk("rst_valid_m", valid_m, 0);
        chk("rst_reg_write_m", reg_write_m, 0);
        chk("rst_mem_write_m", mem_write_m, 0);
        chk("rst_result_src_m", result_src_m, 0);
        chk("rst_rd_m", rd_m, 0);
        chk("rst_alu_m", alu_result_m, 0);
        chk("rst_wdata_m", write_data_m, 0);
        chk("rst_pc4_m", pc_plus4_m, 0);
        chk("rst_busy", ex_busy, 0);
        chk("rst_pc_src", pc_src_e, 0);
        idle();
        tick();
        rst = 1'b0;
        {em_v, em_rw, em_mw, em_rs, em_rd, em_alu, em_wd, em_pc4} = '0;

        for (int c = 0; c < 300; c++) begin
            valid_e = $urandom_range(0, 7) != 0;
            flush_e = $urandom_range(0, 7) == 0;
            stall_m = $urandom_range(0, 5) == 0;
            {reg_write_e, mem_write_e, alu_src_e, branch_e, jump_e, jalr_e} = 6'($urandom);
            mul_e = 1'b0;
            result_src_e = 2'($urandom); alu_ctrl_e = 4'($urandom); br_funct3_e = 3'($urandom);
            fwd_a_e = 2'($urandom); fwd_b_e = 2'($urandom); rd_e = 5'($urandom);
            rd1_e = rnd_val(); rd2_e = rnd_val(); pc_e = rnd_val(); pc_plus4_e = rnd_val();
            imm_ext_e = rnd_val(); result_w = rnd_val();
            ea  = m_fwd(fwd_a_e, rd1_e, result_w, em_alu);
            eb  = m_fwd(fwd_b_e, rd2_e, result_w, em_alu);
            esb = alu_src_e ? imm_ext_e : eb;
            e_tgt = jalr_e ? ((ea + imm_ext_e) & 32'hFFFF_FFFE) : pc_e + imm_ext_e;
            e_src = valid_e && !flush_e && !stall_m && (jump_e || (branch_e && m_taken(br_funct3_e, ea, eb)));
            #1;
            chk("rnd_pc_src", pc_src_e, e_src);
            chk("rnd_target", pc_target_e, e_tgt);
            chk("rnd_busy", ex_busy, 0);
            if (!stall_m) begin
                if (flush_e || !valid_e) begin
                    {em_v, em_rw, em_mw} = '0;
                end else begin
                    {em_v, em_rw, em_mw} = {1'b1, reg_write_e, mem_write_e};
                    em_rs = result_src_e; em_rd = rd_e; em_pc4 = pc_plus4_e;
                    em_alu = m_alu(alu_ctrl_e, ea, esb); em_wd = eb;
                end
            end
            tick();
            chk("rnd_valid_m", valid_m, em_v);
            chk("rnd_reg_write_m", reg_write_m, em_rw);
            chk("rnd_mem_write_m", mem_write_m, em_mw);
            chk("rnd_result_src_m", result_src_m, em_rs);
            chk("rnd_rd_m", rd_m, em_rd);
            chk("rnd_alu_m", alu_result_m, em_alu);
            chk("rnd_wdata_m", write_data_m, em_wd);
            chk("rnd_pc4_m", pc_plus4_m, em_pc4);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
